// File: rtl/ysyx_22051468_wb_gpr_if.sv
// Bus bundle between Exec/decode/debug and the write-back + GPR block.
// The master side drives the Exec triple, the stall and the read addresses. The slave side returns data.
interface ysyx_22051468_wb_gpr_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 5
);
    logic              ex_valid_i;
    logic              ex_w_en_i;
    logic [ADDR_W-1:0] ex_w_addr_i;
    logic [WIDTH-1:0]  ex_w_data_i;
    logic              stall_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [WIDTH-1:0]  rs1_data_o;
    logic [WIDTH-1:0]  rs2_data_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [WIDTH-1:0]  dbg_data_o;
    logic              wb_valid_o;
    logic [63:0]       instret_o;

    modport master (
        output ex_valid_i,
        output ex_w_en_i,
        output ex_w_addr_i,
        output ex_w_data_i,
        output stall_i,
        output rs1_addr_i,
        output rs2_addr_i,
        output dbg_addr_i,
        input  rs1_data_o,
        input  rs2_data_o,
        input  dbg_data_o,
        input  wb_valid_o,
        input  instret_o
    );

    modport slave (
        input  ex_valid_i,
        input  ex_w_en_i,
        input  ex_w_addr_i,
        input  ex_w_data_i,
        input  stall_i,
        input  rs1_addr_i,
        input  rs2_addr_i,
        input  dbg_addr_i,
        output rs1_data_o,
        output rs2_data_o,
        output dbg_data_o,
        output wb_valid_o,
        output instret_o
    );
endinterface

// File: rtl/ysyx_22051468_wb_gpr.sv
// Write-back stage register plus 32-entry GPR file with EX/WB forwarding and a retire counter.
// An Exec result becomes visible in the array two cycles after it appears on the bus.
module ysyx_22051468_wb_gpr #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    ysyx_22051468_wb_gpr_if.slave    bus
);

    logic              wb_valid_q, wb_valid_d;
    logic              wb_w_en_q,  wb_w_en_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q,  wb_data_d;
    logic [63:0]       instret_q,  instret_d;
    logic [WIDTH-1:0]  gpr_q [NREG];
    logic [WIDTH-1:0]  gpr_d [NREG];

    logic ex_fwd;
    logic commit;

    // A write enable without a valid instruction is meaningless and must not leak anywhere.
    assign ex_fwd = bus.ex_valid_i & bus.ex_w_en_i;
    assign commit = wb_w_en_q && (wb_addr_q != '0);

    always_comb begin
        wb_valid_d = 1'b0;
        wb_w_en_d  = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (!bus.stall_i) begin
            wb_valid_d = bus.ex_valid_i;
            wb_w_en_d  = ex_fwd;
            wb_addr_d  = bus.ex_w_addr_i;
            wb_data_d  = bus.ex_w_data_i;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (commit) begin
            gpr_d[wb_addr_q] = wb_data_q;
        end
    end

    assign instret_d = instret_q + 64'(wb_valid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_w_en_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            instret_q  <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_w_en_q  <= wb_w_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            instret_q  <= instret_d;
            for (int unsigned i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // Younger EX result wins over the older WB result for the same register.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (a == '0) begin
            v = '0;
        end else if (ex_fwd && (bus.ex_w_addr_i == a)) begin
            v = bus.ex_w_data_i;
        end else if (wb_w_en_q && (wb_addr_q == a)) begin
            v = wb_data_q;
        end else begin
            v = gpr_q[a];
        end
        return v;
    endfunction

    always_comb begin
        bus.rs1_data_o = read_port(bus.rs1_addr_i);
        bus.rs2_data_o = read_port(bus.rs2_addr_i);
        bus.dbg_data_o = gpr_q[bus.dbg_addr_i];
    end

    assign bus.wb_valid_o = wb_valid_q;
    assign bus.instret_o  = instret_q;

endmodule
